// File: rtl/mips_multicycle_ctrl_if.sv
// Control-bus bundle between the multicycle MIPS control FSM and its datapath.
// The controller uses the slave view; the datapath (or a bench) uses the master view.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             iord;
    logic             irwrite;
    logic             memwrite;
    logic             regwrite;
    logic             regdst;
    logic             memtoreg;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic [1:0]       pcsrc;
    logic             pcen;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;
    logic [CNT_W-1:0] illegal_cnt;
    logic             illegal;

    modport slave (
        input  op, zero, mem_ready,
        output iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, aluop, pcsrc, pcen, state, instret, illegal_cnt, illegal
    );

    modport master (
        output op, zero, mem_ready,
        input  iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, aluop, pcsrc, pcen, state, instret, illegal_cnt, illegal
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS core: sequences PC, memory, register
// file and ALU, stalls on mem_ready, and keeps retired/illegal instruction counters.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_multicycle_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_ORIEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    logic       illegal_s;
    logic       retire_s;
    logic       iord_s, irwrite_s, memwrite_s, regwrite_s, regdst_s, memtoreg_s, alusrca_s;
    logic [1:0] alusrcb_s, aluop_s, pcsrc_s;
    logic       pcwrite_s, branch_s;

    // State and debug counters; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instret_q     <= {CNT_W{1'b0}};
            illegal_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            instret_q     <= instret_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Next-state selection, illegal-opcode detection and retirement.
    always_comb begin
        state_d   = S_FETCH;
        illegal_s = 1'b0;
        retire_s  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
                else               state_d = S_FETCH;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW) state_d = S_MEMRD;
                else                 state_d = S_MEMWR;
            end
            S_MEMRD: begin
                if (bus.mem_ready) state_d = S_MEMWB;
                else               state_d = S_MEMRD;
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d  = S_MEMWR;
                end
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_IMMWB;
            S_ORIEX:   state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        instret_d     = instret_q + CNT_W'(retire_s);
        illegal_cnt_d = illegal_cnt_q + CNT_W'(illegal_s);
    end

    // Moore datapath controls; only FETCH (mem_ready) and BRANCH (zero) see inputs.
    always_comb begin
        iord_s     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        aluop_s    = 2'b00;
        pcsrc_s    = 2'b00;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb_s = 2'b01;
                irwrite_s = bus.mem_ready;
                pcwrite_s = bus.mem_ready;
            end
            S_DECODE:  alusrcb_s = 2'b11;
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            S_MEMRD:   iord_s = 1'b1;
            S_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b10;
            end
            S_ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b01;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            S_IMMWB:   regwrite_s = 1'b1;
            S_JUMP: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
            end
            S_ORIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                aluop_s   = 2'b11;
            end
            default: begin
                alusrcb_s = 2'b00;
            end
        endcase
    end

    // Enables are squashed combinationally so nothing writes while reset is high.
    assign bus.iord        = iord_s;
    assign bus.irwrite     = irwrite_s  & ~reset;
    assign bus.memwrite    = memwrite_s & ~reset;
    assign bus.regwrite    = regwrite_s & ~reset;
    assign bus.pcen        = (pcwrite_s | (branch_s & bus.zero)) & ~reset;
    assign bus.regdst      = regdst_s;
    assign bus.memtoreg    = memtoreg_s;
    assign bus.alusrca     = alusrca_s;
    assign bus.alusrcb     = alusrcb_s;
    assign bus.aluop       = aluop_s;
    assign bus.pcsrc       = pcsrc_s;
    assign bus.state       = state_q;
    assign bus.instret     = instret_q;
    assign bus.illegal_cnt = illegal_cnt_q;
    assign bus.illegal     = illegal_s & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against an opcode-path reference model.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset;

    mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, aluop, pcsrc;
        logic       pcen, illegal, rdy;
    } obs_t;

    obs_t             trace[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_instret = '0;
    logic [CNT_W-1:0] exp_illegal = '0;

    // Runs one instruction from FETCH back to FETCH, recording outputs each cycle.
    task automatic exec_instr(input logic [5:0] o, input logic z, input logic [31:0] mask);
        obs_t ob;
        bit   done = 1'b0;
        trace.delete();
        for (int k = 0; k < 32 && !done; k++) begin
            bus.op = o; bus.zero = z; bus.mem_ready = mask[k];
            #1;
            ob.st = bus.state; ob.iord = bus.iord; ob.irwrite = bus.irwrite;
            ob.memwrite = bus.memwrite; ob.regwrite = bus.regwrite; ob.regdst = bus.regdst;
            ob.memtoreg = bus.memtoreg; ob.alusrca = bus.alusrca; ob.alusrcb = bus.alusrcb;
            ob.aluop = bus.aluop; ob.pcsrc = bus.pcsrc; ob.pcen = bus.pcen;
            ob.illegal = bus.illegal; ob.rdy = mask[k];
            trace.push_back(ob);
            @(posedge clk); #1;
            if (bus.state == 4'd0 && ob.st != 4'd0) done = 1'b1;
            @(negedge clk);
        end
    endtask

    function automatic bit legal_op(input logic [5:0] o);
        return (o == 6'd0 || o == 6'd2 || o == 6'd4 || o == 6'd8 ||
                o == 6'd13 || o == 6'd35 || o == 6'd43);
    endfunction

    // Write enables per state from the state table: {irwrite, memwrite, regwrite, pcen}.
    function automatic logic [3:0] spec_we(input logic [3:0] s, input logic rdy, input logic z);
        case (s)
            4'd0:               return {rdy, 1'b0, 1'b0, rdy};
            4'd4, 4'd7, 4'd10:  return 4'b0010;
            4'd5:               return 4'b0100;
            4'd8:               return {3'b000, z};
            4'd11:              return 4'b0001;
            default:            return 4'b0000;
        endcase
    endfunction

    task automatic test_reset();
        checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL reset_state got %0d want 0", bus.state); end
        checks++; if (bus.instret !== '0) begin failures++; $display("FAIL reset_instret got %0d want 0", bus.instret); end
        checks++; if (bus.illegal_cnt !== '0) begin failures++; $display("FAIL reset_illcnt got %0d want 0", bus.illegal_cnt); end
        checks++;
        if ({bus.irwrite, bus.memwrite, bus.regwrite, bus.pcen, bus.illegal} !== 5'b0) begin
            failures++; $display("FAIL reset_enables got %b want 00000",
                {bus.irwrite, bus.memwrite, bus.regwrite, bus.pcen, bus.illegal});
        end
        checks++; if (bus.alusrcb !== 2'b01) begin failures++; $display("FAIL reset_alusrcb got %b want 01", bus.alusrcb); end
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        exec_instr(6'd0, 1'b0, 32'hFFFF_FFFF);
        exp_instret++;
        checks++; if (trace.size() != 4) begin failures++; $display("FAIL rtype_len got %0d want 4", trace.size()); end
        for (int i = 0; i < 4 && i < trace.size(); i++) begin
            checks++;
            if (trace[i].st !== exp_st[i] || trace[i].regwrite !== (i == 3) || trace[i].regdst !== (i == 3)) begin
                failures++; $display("FAIL rtype_cyc%0d got st=%0d rw=%b rd=%b want st=%0d rw=rd=%b",
                    i, trace[i].st, trace[i].regwrite, trace[i].regdst, exp_st[i], (i == 3));
            end
        end
        if (trace.size() > 2) begin
            checks++; if (trace[2].aluop !== 2'b10) begin failures++; $display("FAIL rtype_aluop got %b want 10", trace[2].aluop); end
        end
        checks++; if (bus.instret !== exp_instret) begin failures++; $display("FAIL rtype_instret got %0d want %0d", bus.instret, exp_instret); end
    endtask

    task automatic test_lw_stall();
        logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        exec_instr(6'd35, 1'b0, 32'hFFFF_FFC7);
        exp_instret++;
        checks++; if (trace.size() != 8) begin failures++; $display("FAIL lw_len got %0d want 8", trace.size()); end
        for (int i = 0; i < 8 && i < trace.size(); i++) begin
            checks++;
            if (trace[i].st !== exp_st[i] || trace[i].iord !== (i >= 3 && i <= 6) ||
                trace[i].regwrite !== (i == 7) || trace[i].memtoreg !== (i == 7)) begin
                failures++; $display("FAIL lw_cyc%0d got st=%0d iord=%b rw=%b m2r=%b want st=%0d",
                    i, trace[i].st, trace[i].iord, trace[i].regwrite, trace[i].memtoreg, exp_st[i]);
            end
        end
        checks++; if (bus.instret !== exp_instret) begin failures++; $display("FAIL lw_instret got %0d want %0d", bus.instret, exp_instret); end
    endtask

    task automatic test_beq();
        for (int zz = 1; zz >= 0; zz--) begin
            exec_instr(6'd4, zz[0], 32'hFFFF_FFFF);
            exp_instret++;
            checks++;
            if (trace.size() != 3) begin
                failures++; $display("FAIL beq_len z=%0d got %0d want 3", zz, trace.size());
            end else if (trace[2].st !== 4'd8 || trace[2].pcen !== zz[0] ||
                         trace[2].pcsrc !== 2'b01 || trace[2].aluop !== 2'b01) begin
                failures++; $display("FAIL beq_z%0d got st=%0d pcen=%b pcsrc=%b aluop=%b want 8 %0d 01 01",
                    zz, trace[2].st, trace[2].pcen, trace[2].pcsrc, trace[2].aluop, zz);
            end
        end
    endtask

    task automatic test_ori();
        exec_instr(6'd13, 1'b0, 32'hFFFF_FFFF);
        exp_instret++;
        checks++;
        if (trace.size() != 4) begin
            failures++; $display("FAIL ori_len got %0d want 4", trace.size());
        end else begin
            if (trace[2].st !== 4'd12 || trace[2].aluop !== 2'b11 || trace[2].alusrcb !== 2'b10) begin
                failures++; $display("FAIL ori_ex got st=%0d aluop=%b srcb=%b want 12 11 10",
                    trace[2].st, trace[2].aluop, trace[2].alusrcb);
            end
            checks++;
            if (trace[3].st !== 4'd10 || trace[3].regwrite !== 1'b1 || trace[3].regdst !== 1'b0) begin
                failures++; $display("FAIL ori_wb got st=%0d rw=%b rd=%b want 10 1 0",
                    trace[3].st, trace[3].regwrite, trace[3].regdst);
            end
        end
    endtask

    task automatic test_illegal();
        exec_instr(6'd63, 1'b0, 32'hFFFF_FFFF);
        exp_illegal++;
        checks++;
        if (trace.size() != 2) begin
            failures++; $display("FAIL ill_len got %0d want 2", trace.size());
        end else if (trace[0].illegal !== 1'b0 || trace[1].illegal !== 1'b1 ||
                     {trace[1].irwrite, trace[1].memwrite, trace[1].regwrite, trace[1].pcen} !== 4'b0) begin
            failures++; $display("FAIL ill_pulse got ill=%b%b we=%b want 01 0000", trace[0].illegal, trace[1].illegal,
                {trace[1].irwrite, trace[1].memwrite, trace[1].regwrite, trace[1].pcen});
        end
        checks++; if (bus.illegal_cnt !== exp_illegal) begin failures++; $display("FAIL ill_cnt got %0d want %0d", bus.illegal_cnt, exp_illegal); end
        checks++; if (bus.instret !== exp_instret) begin failures++; $display("FAIL ill_instret got %0d want %0d", bus.instret, exp_instret); end
    endtask

    task automatic test_random();
        logic [5:0]  ops [8] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd13, 6'd35, 6'd43, 6'd0};
        logic [5:0]  o;
        logic        z;
        logic [31:0] mask;
        logic [3:0]  path[$];
        logic [3:0]  exp_st[$];
        logic [3:0]  s, we;
        int          sel, idx;
        for (int n = 0; n < 60; n++) begin
            sel  = $urandom_range(0, 7);
            o    = (sel == 7) ? 6'($urandom_range(0, 63)) : ops[sel];
            z    = 1'($urandom_range(0, 1));
            mask = {16'hFFFF, 16'($urandom | $urandom)};
            case (o)
                6'd0:         path = '{4'd0, 4'd1, 4'd6, 4'd7};
                6'd2:         path = '{4'd0, 4'd1, 4'd11};
                6'd4:         path = '{4'd0, 4'd1, 4'd8};
                6'd8:         path = '{4'd0, 4'd1, 4'd9, 4'd10};
                6'd13:        path = '{4'd0, 4'd1, 4'd12, 4'd10};
                6'd35:        path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
                6'd43:        path = '{4'd0, 4'd1, 4'd2, 4'd5};
                default:      path = '{4'd0, 4'd1};
            endcase
            exp_st.delete();
            idx = 0;
            for (int k = 0; k < 32 && idx < path.size(); k++) begin
                s = path[idx];
                exp_st.push_back(s);
                if (!((s == 4'd0 || s == 4'd3 || s == 4'd5) && !mask[k])) idx++;
            end
            if (legal_op(o)) exp_instret++;
            else             exp_illegal++;
            exec_instr(o, z, mask);
            checks++;
            if (trace.size() != exp_st.size()) begin
                failures++; $display("FAIL rnd%0d_len op=%0d got %0d want %0d", n, o, trace.size(), exp_st.size());
            end
            for (int i = 0; i < trace.size() && i < exp_st.size(); i++) begin
                we = spec_we(exp_st[i], trace[i].rdy, z);
                checks++;
                if (trace[i].st !== exp_st[i] ||
                    {trace[i].irwrite, trace[i].memwrite, trace[i].regwrite, trace[i].pcen} !== we ||
                    trace[i].iord !== (exp_st[i] == 4'd3 || exp_st[i] == 4'd5) ||
                    trace[i].illegal !== (exp_st[i] == 4'd1 && !legal_op(o))) begin
                    failures++; $display("FAIL rnd%0d_cyc%0d op=%0d got st=%0d we=%b iord=%b ill=%b want st=%0d we=%b",
                        n, i, o, trace[i].st,
                        {trace[i].irwrite, trace[i].memwrite, trace[i].regwrite, trace[i].pcen},
                        trace[i].iord, trace[i].illegal, exp_st[i], we);
                end
            end
            checks++;
            if (bus.instret !== exp_instret || bus.illegal_cnt !== exp_illegal) begin
                failures++; $display("FAIL rnd%0d_cnt got %0d/%0d want %0d/%0d", n,
                    bus.instret, bus.illegal_cnt, exp_instret, exp_illegal);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        bus.op = 6'd43; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd5 || bus.memwrite !== 1'b1) begin
            failures++; $display("FAIL midwr_pre got st=%0d mw=%b want 5 1", bus.state, bus.memwrite);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.memwrite !== 1'b0 || bus.state !== 4'd0 || bus.instret !== '0 || bus.illegal_cnt !== '0 ||
            bus.regwrite !== 1'b0 || bus.irwrite !== 1'b0 || bus.pcen !== 1'b0) begin
            failures++; $display("FAIL midwr_reset got mw=%b st=%0d ir=%0d ic=%0d want 0 0 0 0",
                bus.memwrite, bus.state, bus.instret, bus.illegal_cnt);
        end
        exp_instret = '0;
        exp_illegal = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.op = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_ori();
        test_illegal();
        test_random();
        test_reset_midwrite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
